if_fetch_ctrl: RTL

Instruction-fetch sequencer between the PC/fetch stage and the instruction memory port. It owns the fetch PC and issues one request at a time over a req/ack memory handshake that tolerates variable latency. It presents each fetched instruction to the decode stage over a valid/ready handshake. It also handles PC redirects from execute, including redirects that arrive while a memory request is outstanding.

---
 rtl/if_fetch_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one memory request at a
// time over req/ack, presents fetched instructions to decode over valid/ready.
module if_fetch_ctrl #(
    parameter int unsigned          ADDR_W   = 64,
    parameter int unsigned          INST_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    input  logic              out_ready
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;
    localparam logic [1:0] DISCARD = 2'd3;

    logic [1:0]        state_q,  state_d;
    logic [ADDR_W-1:0] fetch_q,  fetch_d;
    logic [ADDR_W-1:0] pend_q,   pend_d;
    logic              valid_d;
    logic [ADDR_W-1:0] opc_d;
    logic [INST_W-1:0] oinst_d;
    logic [ADDR_W-1:0] redirect_tgt;
    logic [ADDR_W-1:0] fetch_inc;
    logic              unused_redirect_lsb;

    // Targets are word aligned; the two low bits are dropped.
    assign redirect_tgt        = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign fetch_inc           = fetch_q + ADDR_W'(4);

    assign mem_req  = (state_q == REQ) || (state_q == DISCARD);
    assign mem_addr = fetch_q;

    always_comb begin
        state_d = state_q;
        fetch_d = fetch_q;
        pend_d  = pend_q;
        valid_d = out_valid;
        opc_d   = out_pc;
        oinst_d = out_inst;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_d = redirect_tgt;
                end
                state_d = REQ;
            end
            REQ: begin
                if (redirect_valid) begin
                    // An unacked address cannot be withdrawn: wait it out in DISCARD.
                    if (mem_ack) begin
                        fetch_d = redirect_tgt;
                    end else begin
                        pend_d  = redirect_tgt;
                        state_d = DISCARD;
                    end
                end else if (mem_ack) begin
                    oinst_d = mem_rdata;
                    opc_d   = fetch_q;
                    valid_d = 1'b1;
                    fetch_d = fetch_inc;
                    state_d = HOLD;
                end
            end
            DISCARD: begin
                if (mem_ack) begin
                    fetch_d = redirect_valid ? redirect_tgt : pend_q;
                    state_d = REQ;
                end else if (redirect_valid) begin
                    pend_d = redirect_tgt;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    fetch_d = redirect_tgt;
                    state_d = REQ;
                end else if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            fetch_q   <= RESET_PC;
            pend_q    <= RESET_PC;
            out_valid <= 1'b0;
            out_pc    <= RESET_PC;
            out_inst  <= '0;
        end else begin
            state_q   <= state_d;
            fetch_q   <= fetch_d;
            pend_q    <= pend_d;
            out_valid <= valid_d;
            out_pc    <= opc_d;
            out_inst  <= oinst_d;
        end
    end

endmodule
